// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle HI/LO multiply/divide unit with a fixed busy
//               countdown, MTHI/MTLO writes and a combinational HI/LO read.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int MUL_LATENCY = 5,
    parameter int DIV_LATENCY = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  operation,
    input  logic        writeEnable,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic [31:0] dataRead
);

    // Operation encoding: bit 2 clear marks the START_* group, bit 1 selects
    // divide, bit 0 selects unsigned.
    localparam logic [2:0] c_OP_SIGNED_MUL   = 3'd0;
    localparam logic [2:0] c_OP_UNSIGNED_MUL = 3'd1;
    localparam logic [2:0] c_OP_SIGNED_DIV   = 3'd2;
    localparam logic [2:0] c_OP_UNSIGNED_DIV = 3'd3;
    localparam logic [2:0] c_OP_READ_HI      = 3'd4;
    localparam logic [2:0] c_OP_READ_LO      = 3'd5;
    localparam logic [2:0] c_OP_WRITE_HI     = 3'd6;
    localparam logic [2:0] c_OP_WRITE_LO     = 3'd7;

    localparam int c_MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_MUL_CNT = c_CNT_W'(MUL_LATENCY);
    localparam logic [c_CNT_W-1:0] c_DIV_CNT = c_CNT_W'(DIV_LATENCY);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_CNT_W-1:0] r_count;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_op1;
    logic [31:0]        r_op2;
    logic [1:0]         r_op;

    logic               w_launch;
    logic               w_commit;
    logic               w_write_hi;
    logic               w_write_lo;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: if (w_launch) w_state_next = c_BUSY;
            c_BUSY: if (r_count == c_CNT_ONE) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs / control strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_launch   = 1'b0;
        w_commit   = 1'b0;
        w_write_hi = 1'b0;
        w_write_lo = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_launch = start && !operation[2];
                // Any start request, even an ignored one, drops a same-cycle write.
                w_write_hi = !start && writeEnable && (operation == c_OP_WRITE_HI);
                w_write_lo = !start && writeEnable && (operation == c_OP_WRITE_LO);
            end
            c_BUSY: begin
                w_commit = (r_count == c_CNT_ONE);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Arithmetic on captured operands
    // ------------------------------------------------------------------------
    logic        w_is_div;
    logic        w_is_signed;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_product;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_den;
    logic [31:0] w_uquot;
    logic [31:0] w_urem;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_zero;

    assign w_is_div    = r_op[1];
    assign w_is_signed = !r_op[0];

    assign w_mul_a   = {{32{w_is_signed & r_op1[31]}}, r_op1};
    assign w_mul_b   = {{32{w_is_signed & r_op2[31]}}, r_op2};
    assign w_product = w_mul_a * w_mul_b;

    // Magnitude division then sign fix-up: truncation toward zero, remainder
    // follows the dividend, and 0x80000000 / -1 wraps to 0x80000000 naturally.
    assign w_a_neg    = w_is_signed & r_op1[31];
    assign w_b_neg    = w_is_signed & r_op2[31];
    assign w_abs_a    = w_a_neg ? (~r_op1 + 32'd1) : r_op1;
    assign w_abs_b    = w_b_neg ? (~r_op2 + 32'd1) : r_op2;
    assign w_div_zero = (r_op2 == 32'd0);
    assign w_den      = w_div_zero ? 32'd1 : w_abs_b;
    assign w_uquot    = w_abs_a / w_den;
    assign w_urem     = w_abs_a % w_den;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (~w_uquot + 32'd1) : w_uquot;
    assign w_rem      = w_a_neg ? (~w_urem + 32'd1) : w_urem;

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_op1   <= 32'd0;
            r_op2   <= 32'd0;
            r_op    <= 2'd0;
        end else begin
            r_busy <= (w_state_next == c_BUSY);
            if (w_launch) begin
                r_op1   <= operand1;
                r_op2   <= operand2;
                r_op    <= operation[1:0];
                r_count <= operation[1] ? c_DIV_CNT : c_MUL_CNT;
            end else if (r_state == c_BUSY) begin
                r_count <= r_count - c_CNT_ONE;
            end
            if (w_commit) begin
                if (!w_is_div) begin
                    r_hi <= w_product[63:32];
                    r_lo <= w_product[31:0];
                end else if (!w_div_zero) begin
                    r_hi <= w_rem;
                    r_lo <= w_quot;
                end
            end
            if (w_write_hi) r_hi <= operand1;
            if (w_write_lo) r_lo <= operand1;
        end
    end

    assign busy = r_busy;

    always_comb begin
        dataRead = 32'd0;
        if (operation == c_OP_READ_HI) dataRead = r_hi;
        else if (operation == c_OP_READ_LO) dataRead = r_lo;
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [2:0] OP_SMUL = 3'd0;
    localparam logic [2:0] OP_UMUL = 3'd1;
    localparam logic [2:0] OP_SDIV = 3'd2;
    localparam logic [2:0] OP_UDIV = 3'd3;
    localparam logic [2:0] OP_RDHI = 3'd4;
    localparam logic [2:0] OP_RDLO = 3'd5;
    localparam logic [2:0] OP_WRHI = 3'd6;
    localparam logic [2:0] OP_WRLO = 3'd7;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  operation;
    logic        writeEnable;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic [31:0] dataRead;

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mul_div_unit #(
        .MUL_LATENCY(MUL_LAT),
        .DIV_LATENCY(DIV_LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .operation  (operation),
        .writeEnable(writeEnable),
        .operand1   (operand1),
        .operand2   (operand2),
        .busy       (busy),
        .dataRead   (dataRead)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        operation = OP_RDHI;
        #1 check({tag, "_hi"}, dataRead, eh);
        operation = OP_RDLO;
        #1 check({tag, "_lo"}, dataRead, el);
    endtask

    // Launch at the next edge; afterwards operands are scrambled since they
    // are only meaningful in the start cycle.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        operation = op;
        operand1 = a;
        operand2 = b;
        step();
        start = 1'b0;
        operation = OP_RDLO;
        operand1 = $urandom;
        operand2 = $urandom;
    endtask

    // Called just after the launch edge: busy for lat cycles with old HI/LO
    // visible, then results appear on the edge where busy falls.
    task automatic wait_done(input string tag, input int lat, input logic [31:0] eh, input logic [31:0] el);
        for (int i = 0; i < lat; i++) begin
            operation = OP_RDLO;
            #1 check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_lo_hold"}, dataRead, m_lo);
            step();
            #0;
        end
        check({tag, "_done"}, {31'd0, busy}, 32'd0);
        read_hilo(tag, eh, el);
        m_hi = eh;
        m_lo = el;
    endtask

    task automatic do_write(input logic [2:0] op, input logic [31:0] v);
        operation = op;
        writeEnable = 1'b1;
        operand1 = v;
        step();
        writeEnable = 1'b0;
        operand1 = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        writeEnable = 1'b0;
        operation = OP_RDHI;
        operand1 = 32'd0;
        operand2 = 32'd0;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        read_hilo("rst", 32'd0, 32'd0);
        step();
        reset = 1'b0;
        step();

        operation = OP_SMUL;
        #1 check("idle_read_other", dataRead, 32'd0);

        start_op(OP_SMUL, 32'hFFFF_FFFE, 32'h0000_0003);
        wait_done("smul", MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        start_op(OP_UMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("umul", MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001);

        // Collision: second start and a WRITE_HI during busy are both ignored.
        start_op(OP_UMUL, 32'd6, 32'd7);
        #1 check("col_c1", {31'd0, busy}, 32'd1);
        step();
        start = 1'b1; operation = OP_WRHI; writeEnable = 1'b1; operand1 = 32'h0000_0BAD;
        #1 check("col_c2", {31'd0, busy}, 32'd1);
        step();
        operation = OP_UDIV; writeEnable = 1'b0; operand1 = 32'd9; operand2 = 32'd2;
        #1 check("col_c3", {31'd0, busy}, 32'd1);
        step();
        start = 1'b0;
        operation = OP_RDHI;
        #1 check("col_hi_hold", dataRead, 32'hFFFF_FFFE);
        check("col_c4", {31'd0, busy}, 32'd1);
        step();
        #1 check("col_c5", {31'd0, busy}, 32'd1);
        step();
        #1 check("col_done", {31'd0, busy}, 32'd0);
        read_hilo("col", 32'd0, 32'd42);
        m_hi = 32'd0; m_lo = 32'd42;

        start_op(OP_SDIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done("sdiv", DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        start_op(OP_UDIV, 32'd7, 32'd2);
        wait_done("udiv", DIV_LAT, 32'd1, 32'd3);

        do_write(OP_WRHI, 32'h11);
        read_hilo("wrhi", 32'h11, 32'd3);
        do_write(OP_WRLO, 32'h22);
        read_hilo("wrlo", 32'h11, 32'h22);
        m_hi = 32'h11; m_lo = 32'h22;

        start_op(OP_SDIV, 32'd5, 32'd0);
        wait_done("div0", DIV_LAT, 32'h11, 32'h22);

        start_op(OP_SDIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("ovf", DIV_LAT, 32'd0, 32'h8000_0000);

        // Non-START op with start=1 is ignored, and its write is dropped too.
        start = 1'b1; writeEnable = 1'b1; operation = OP_WRHI; operand1 = 32'hDEAD_BEEF;
        step();
        start = 1'b0; writeEnable = 1'b0;
        #1 check("nonstart_busy", {31'd0, busy}, 32'd0);
        read_hilo("start_wins", 32'd0, 32'h8000_0000);

        // Reset on busy cycle 3 of a divide aborts it immediately.
        start_op(OP_UDIV, 32'd100, 32'd7);
        step();
        step();
        reset = 1'b1;
        #1 check("rstmid_busy", {31'd0, busy}, 32'd0);
        read_hilo("rstmid", 32'd0, 32'd0);
        step();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        step();
        check("rstmid_idle", {31'd0, busy}, 32'd0);
        start_op(OP_UMUL, 32'd3, 32'd4);
        wait_done("post_rst", MUL_LAT, 32'd0, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
